// File: rtl/serial_shift_out_pkg.sv
// -----------------------------------------------------------------------------
// serial_shift_out_pkg
//   Shared constants for the serial shift-out path.
//   SHIFT_MSB_FIRST / SHIFT_LSB_FIRST select the bit order fed to the chain.
// -----------------------------------------------------------------------------
package serial_shift_out_pkg;

   localparam bit SHIFT_MSB_FIRST = 1'b0;
   localparam bit SHIFT_LSB_FIRST = 1'b1;

endpackage

// File: rtl/serial_shift_out.sv
// -----------------------------------------------------------------------------
// serial_shift_out
//   Serialises parallel words onto a 74HC595-style chain (SCLK, SDATA, LATCH).
//   All serial edges are paced by a one-cycle i_tick enable, so everything stays
//   in the i_clk domain. A one-entry holding buffer accepts the next word while
//   the current word shifts, letting back-to-back words stream without gaps.
//
// Ports
//   i_clk      system clock
//   i_reset_n  asynchronous active-low reset
//   i_tick     serial-rate enable, one i_clk cycle wide
//   i_data     word to transmit
//   i_valid    i_data valid; accepted on i_valid & o_ready
//   o_ready    holding buffer empty (registered)
//   o_sclk     shift clock to chain (registered)
//   o_sdata    serial data to chain (registered)
//   o_latch    storage-register latch pulse (registered)
//   o_busy     shift or latch sequence in progress (registered)
// -----------------------------------------------------------------------------
module serial_shift_out
   import serial_shift_out_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter bit LSB_FIRST = SHIFT_MSB_FIRST
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_tick,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_valid,
   output logic             o_ready,
   output logic             o_sclk,
   output logic             o_sdata,
   output logic             o_latch,
   output logic             o_busy
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SHIFT_LO = 3'd1,
      ST_SHIFT_HI = 3'd2,
      ST_LATCH_HI = 3'd3,
      ST_LATCH_LO = 3'd4
   } state_t;

   state_t             r_state,   w_state;
   logic [WIDTH-1:0]   r_buf,     w_buf;
   logic               r_buf_full, w_buf_full;
   logic               r_ready;
   logic [WIDTH-1:0]   r_shift,   w_shift;
   logic [CNT_W-1:0]   r_bit_cnt, w_bit_cnt;
   logic               r_sclk,    w_sclk;
   logic               r_sdata,   w_sdata;
   logic               r_latch,   w_latch;
   logic               r_busy;
   logic               w_handoff;
   logic               w_accept;

   always_comb begin
      w_state   = r_state;
      w_shift   = r_shift;
      w_bit_cnt = r_bit_cnt;
      w_sclk    = r_sclk;
      w_sdata   = r_sdata;
      w_latch   = r_latch;
      w_handoff = 1'b0;

      unique case (r_state)
         // Leaving IDLE does not wait for a tick so the first SHIFT_LO tick
         // already drives data.
         ST_IDLE: begin
            if (r_buf_full) begin
               w_handoff = 1'b1;
               w_state   = ST_SHIFT_LO;
            end
         end
         ST_SHIFT_LO: begin
            if (i_tick) begin
               w_sclk  = 1'b0;
               w_sdata = LSB_FIRST ? r_shift[0] : r_shift[WIDTH-1];
               w_state = ST_SHIFT_HI;
            end
         end
         ST_SHIFT_HI: begin
            if (i_tick) begin
               w_sclk  = 1'b1;
               w_shift = LSB_FIRST ? (r_shift >> 1) : (r_shift << 1);
               if (r_bit_cnt == CNT_W'(WIDTH - 1)) begin
                  w_state = ST_LATCH_HI;
               end else begin
                  w_bit_cnt = r_bit_cnt + CNT_W'(1);
                  w_state   = ST_SHIFT_LO;
               end
            end
         end
         ST_LATCH_HI: begin
            if (i_tick) begin
               w_sclk  = 1'b0;
               w_latch = 1'b1;
               w_state = ST_LATCH_LO;
            end
         end
         ST_LATCH_LO: begin
            // Reloading here keeps consecutive words gap-free.
            if (i_tick) begin
               w_latch = 1'b0;
               if (r_buf_full) begin
                  w_handoff = 1'b1;
                  w_state   = ST_SHIFT_LO;
               end else begin
                  w_state   = ST_IDLE;
               end
            end
         end
         default: w_state = ST_IDLE;
      endcase

      if (w_handoff) begin
         w_shift   = r_buf;
         w_bit_cnt = '0;
      end

      // A same-cycle accept wins over the hand-off so the buffer stays full.
      w_accept   = i_valid & r_ready;
      w_buf      = w_accept ? i_data : r_buf;
      w_buf_full = w_accept ? 1'b1 : (w_handoff ? 1'b0 : r_buf_full);
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state    <= ST_IDLE;
         r_buf      <= '0;
         r_buf_full <= 1'b0;
         r_ready    <= 1'b0;
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_sclk     <= 1'b0;
         r_sdata    <= 1'b0;
         r_latch    <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_buf      <= w_buf;
         r_buf_full <= w_buf_full;
         r_ready    <= ~w_buf_full;
         r_shift    <= w_shift;
         r_bit_cnt  <= w_bit_cnt;
         r_sclk     <= w_sclk;
         r_sdata    <= w_sdata;
         r_latch    <= w_latch;
         r_busy     <= (w_state != ST_IDLE);
      end
   end

   assign o_ready = r_ready;
   assign o_sclk  = r_sclk;
   assign o_sdata = r_sdata;
   assign o_latch = r_latch;
   assign o_busy  = r_busy;

endmodule

// File: tb/tb_serial_shift_out.sv
// -----------------------------------------------------------------------------
// tb_serial_shift_out
//   Two DUTs (MSB-first and LSB-first, WIDTH=8) share one stimulus stream.
//   Accepted words go into a scoreboard queue; a monitor per DUT decodes the
//   serial lines and compares sampled bits, latch pulses and tick budgets.
// -----------------------------------------------------------------------------
module tb_serial_shift_out;

   localparam int W   = 8;
   localparam int TPW = 2 * W + 2;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         tick = 1'b0;
   logic         valid = 1'b0;
   logic [W-1:0] data = '0;
   logic [1:0]   ready, sclk, sdata, latch, busy;

   int n_chk  = 0;
   int n_fail = 0;
   logic [W-1:0] exp_words[$];
   bit  full_rate = 1'b0;
   int  tick_ph = 0;

   always #5 clk = ~clk;

   serial_shift_out #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
      .i_clk(clk), .i_reset_n(rst_n), .i_tick(tick), .i_data(data), .i_valid(valid),
      .o_ready(ready[0]), .o_sclk(sclk[0]), .o_sdata(sdata[0]), .o_latch(latch[0]),
      .o_busy(busy[0]));

   serial_shift_out #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
      .i_clk(clk), .i_reset_n(rst_n), .i_tick(tick), .i_data(data), .i_valid(valid),
      .o_ready(ready[1]), .o_sclk(sclk[1]), .o_sdata(sdata[1]), .o_latch(latch[1]),
      .o_busy(busy[1]));

   // clk_div stand-in: one-cycle pulse every 4 clocks, or every cycle at full rate.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         tick    = full_rate ? 1'b1 : (tick_ph == 3);
         tick_ph = (tick_ph + 1) % 4;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Position k of the serial stream, straight from the bit-order rule.
   function automatic logic exp_bit(input logic [W-1:0] w, input int k, input bit lsb);
      return lsb ? w[k] : w[W-1-k];
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_mon
      int   rd_idx = 0, bitpos = 0, burst_ticks = 0, burst_words = 0;
      int   latch_ticks = 0, latches = 0;
      logic p_sclk = 1'b0, p_sdata = 1'b0, p_latch = 1'b0, p_busy = 1'b0;

      always @(negedge clk) begin
         if (!rst_n) begin
            check("reset_outputs", {27'd0, ready[g], sclk[g], sdata[g], latch[g], busy[g]}, 32'd0);
            rd_idx = exp_words.size();
            bitpos = 0; burst_ticks = 0; burst_words = 0; latch_ticks = 0;
            p_sclk = 1'b0; p_sdata = 1'b0; p_latch = 1'b0; p_busy = 1'b0;
         end else begin
            if (busy[g] && tick) burst_ticks++;
            if (sclk[g] && !p_sclk) begin
               check("sdata_setup", sdata[g], p_sdata);
               if (rd_idx >= exp_words.size())
                  check("spurious_sclk", rd_idx, exp_words.size());
               else
                  check("bit", sdata[g], exp_bit(exp_words[rd_idx], bitpos, g == 1));
               bitpos++;
            end
            if (latch[g] && !p_latch) begin
               check("latch_bitcount", bitpos, W);
               rd_idx++; bitpos = 0; burst_words++; latches++; latch_ticks = 0;
            end
            if (latch[g] && tick) latch_ticks++;
            if (!latch[g] && p_latch) check("latch_width_ticks", latch_ticks, 1);
            if (!busy[g] && p_busy) begin
               check("burst_ticks", burst_ticks, TPW * burst_words);
               burst_ticks = 0; burst_words = 0;
            end
            p_sclk = sclk[g]; p_sdata = sdata[g]; p_latch = latch[g]; p_busy = busy[g];
         end
      end
   end

   task automatic send(input logic [W-1:0] w);
      int t = 0;
      @(negedge clk);
      while (!ready[0] && t < 2000) begin @(negedge clk); t++; end
      if (t >= 2000) check("send_timeout", t, 0);
      valid = 1'b1; data = w;
      @(posedge clk); #1;
      valid = 1'b0;
      exp_words.push_back(w);
   endtask

   task automatic wait_idle();
      int t = 0;
      @(negedge clk);
      while ((busy[0] || busy[1] || !ready[0]) && t < 5000) begin @(negedge clk); t++; end
      if (t >= 5000) check("idle_timeout", t, 0);
      repeat (2) @(negedge clk);
   endtask

   int l0, l1;
   task automatic mark(); l0 = g_mon[0].latches; l1 = g_mon[1].latches; endtask
   task automatic check_latches(input string name, input int n);
      check({name, "_msb"}, g_mon[0].latches - l0, n);
      check({name, "_lsb"}, g_mon[1].latches - l1, n);
   endtask

   initial begin
      int rises, t;
      logic ps;

      // Reset held with i_valid asserted: nothing captured, ready low.
      valid = 1'b1; data = 8'hA5;
      repeat (5) @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1; valid = 1'b0;
      @(negedge clk);
      check("ready_before_first_edge", ready[0], 1'b0);
      @(negedge clk);
      check("ready_after_first_edge", ready[0], 1'b1);
      check("busy_after_reset", busy[0], 1'b0);

      // Single words, MSB and LSB order checked by each monitor.
      mark(); send(8'hA5); wait_idle(); check_latches("single_A5", 1);
      check("busy_idle", busy[0], 1'b0);
      mark(); send(8'h01); wait_idle(); check_latches("single_01", 1);

      // Back-to-back: second word waits in the buffer, 36 ticks, no idle gap.
      mark(); send(8'hFF); send(8'h00); wait_idle(); check_latches("b2b", 2);

      // Reset after third sclk rise aborts the word without a latch.
      mark(); send(8'h3C);
      rises = 0; t = 0; ps = 1'b0;
      while (rises < 3 && t < 2000) begin
         @(negedge clk);
         if (sclk[0] && !ps) rises++;
         ps = sclk[0]; t++;
      end
      if (t >= 2000) check("rise_timeout", t, 0);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_outputs", {27'd0, ready[0], sclk[0], sdata[0], latch[0], busy[0]}, 32'd0);
      repeat (3) @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b1;
      check_latches("aborted", 0);
      mark(); send(8'hC3); wait_idle(); check_latches("post_reset", 1);

      // Full rate; valid pulses while the buffer is full must be dropped.
      full_rate = 1'b1;
      mark(); send(8'h5A); send(8'h96);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (!ready[0]) begin
            valid = 1'b1; data = 8'(k * 37 + 11);
            @(posedge clk); #1 valid = 1'b0;
         end
      end
      wait_idle(); check_latches("full_rate", 2);
      full_rate = 1'b0;

      // Random words, tick rates and gaps.
      mark();
      for (int k = 0; k < 30; k++) begin
         full_rate = ($urandom_range(0, 1) == 1);
         send(8'($urandom));
         repeat ($urandom_range(0, 20)) @(posedge clk);
      end
      wait_idle(); check_latches("random", 30);

      check("drained_msb", g_mon[0].rd_idx, exp_words.size());
      check("drained_lsb", g_mon[1].rd_idx, exp_words.size());

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
